// File: rtl/deemph_pkg.sv
`default_nettype none
// ============================================================================
// Module      : deemph_pkg
// Description : Shared widths, saturation limits and FSM state encoding for
//               the decoder de-emphasis filter and its saturation helper.
// Revision    : 1.0  initial release
// ============================================================================
package deemph_pkg;

    localparam int IN_W  = 17;  // pre-emphasised input sample width
    localparam int OUT_W = 16;  // saturated PCM output width
    localparam int SUM_W = 18;  // accumulator width; x + (y >>> k) cannot overflow

    localparam logic signed [SUM_W-1:0] SAT_MAX = 18'sd32767;
    localparam logic signed [SUM_W-1:0] SAT_MIN = -18'sd32768;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

endpackage
`default_nettype wire

// File: rtl/deemph_saturate.sv
`default_nettype none
// ============================================================================
// Module      : deemph_saturate
// Description : Combinational clip of a SUM_W-bit signed value to the OUT_W
//               signed range, with a flag marking that clipping occurred.
// Revision    : 1.0  initial release
// ============================================================================
module deemph_saturate
    import deemph_pkg::*;
(
    input  logic [SUM_W-1:0] i_sum,
    output logic [OUT_W-1:0] o_y,
    output logic             o_clip
);

    logic signed [SUM_W-1:0] w_sum_s;
    assign w_sum_s = $signed(i_sum);

    // Clamp to the output range; in-range values pass through unchanged
    always_comb begin
        o_y    = i_sum[OUT_W-1:0];
        o_clip = 1'b0;
        if (w_sum_s > SAT_MAX) begin
            o_y    = SAT_MAX[OUT_W-1:0];
            o_clip = 1'b1;
        end else if (w_sum_s < SAT_MIN) begin
            o_y    = SAT_MIN[OUT_W-1:0];
            o_clip = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/de_emphasis.sv
`default_nettype none
// ============================================================================
// Module      : de_emphasis
// Description : First-order recursive de-emphasis filter,
//               y[n] = sat16(x[n] + (y[n-1] >>> SHIFT_K)), with a
//               valid/ready handshake on both sides and filter memory
//               cleared at subframe boundaries.
//               Optional: define DEEMPH_SAT_CNT_EN to add a saturating
//               per-subframe clip counter on port sat_count.
// Revision    : 1.0  initial release
// ============================================================================
module de_emphasis
    import deemph_pkg::*;
#(
    parameter int SHIFT_K = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             new_subframe,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             sat_flag
`ifdef DEEMPH_SAT_CNT_EN
    ,
    output logic [15:0]      sat_count
`endif
);

    logic [1:0]              r_state;
    logic [1:0]              w_next_state;
    logic [IN_W-1:0]         r_x_reg;
    logic [OUT_W-1:0]        r_y_prev;
    logic [OUT_W-1:0]        r_out_data;
    logic                    r_sat_flag;
    logic                    r_clr_pend;

    logic signed [OUT_W-1:0] w_y_prev_s;
    logic signed [OUT_W-1:0] w_y_shift;
    logic [SUM_W-1:0]        w_sum;
    logic [OUT_W-1:0]        w_y;
    logic                    w_clip;
    logic                    w_clear;

    // Feedback term: arithmetic shift, so negative memory rounds toward -inf
    assign w_y_prev_s = $signed(r_y_prev);
    assign w_y_shift  = w_y_prev_s >>> SHIFT_K;
    assign w_sum      = {r_x_reg[IN_W-1], r_x_reg}
                      + {{(SUM_W-OUT_W){w_y_shift[OUT_W-1]}}, w_y_shift};

    deemph_saturate u_sat (
        .i_sum  (w_sum),
        .o_y    (w_y),
        .o_clip (w_clip)
    );

    // Filter memory is zeroed either straight away in IDLE or, if the pulse
    // arrived mid-sample, when the current result has been handed off
    assign w_clear = ((r_state == IDLE) && new_subframe) ||
                     ((r_state == HOLD) && out_ready && (r_clr_pend || new_subframe));

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    // Next-state decode
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_next_state = CALC;
            CALC:                   w_next_state = HOLD;
            HOLD:    if (out_ready) w_next_state = IDLE;
            default:                w_next_state = IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        in_ready  = (r_state == IDLE);
        out_valid = (r_state == HOLD);
    end

    // Datapath: sample capture, result/flag registers, filter memory
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x_reg    <= '0;
            r_y_prev   <= '0;
            r_out_data <= '0;
            r_sat_flag <= 1'b0;
            r_clr_pend <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) r_x_reg <= in_data;
                end
                CALC: begin
                    r_out_data <= w_y;
                    r_sat_flag <= w_clip;
                    r_y_prev   <= w_y;
                    if (new_subframe) r_clr_pend <= 1'b1;
                end
                HOLD: begin
                    if (out_ready)         r_clr_pend <= 1'b0;
                    else if (new_subframe) r_clr_pend <= 1'b1;
                end
                default: ;
            endcase
            if (w_clear) r_y_prev <= '0;
        end
    end

    assign out_data = r_out_data;
    assign sat_flag = r_sat_flag;

`ifdef DEEMPH_SAT_CNT_EN
    logic [15:0] r_sat_count;

    // Clip counter: cleared with the filter memory, sticks at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sat_count <= '0;
        end else if (w_clear) begin
            r_sat_count <= '0;
        end else if ((r_state == CALC) && w_clip && (r_sat_count != 16'hFFFF)) begin
            r_sat_count <= r_sat_count + 16'd1;
        end
    end

    assign sat_count = r_sat_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_de_emphasis.sv
`default_nettype none
// ============================================================================
// Module      : tb_de_emphasis
// Description : Self-checking bench for de_emphasis: vector table for the
//               filter arithmetic plus hand-written handshake sequences.
// Revision    : 1.0  initial release
// ============================================================================
module tb_de_emphasis;

    logic        clk = 1'b0;
    logic        rst;
    logic        new_subframe;
    logic        in_valid;
    logic        in_ready;
    logic [16:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        sat_flag;
`ifdef DEEMPH_SAT_CNT_EN
    logic [15:0] sat_count;
`endif

    int checks = 0;
    int passes = 0;
    int cnt_model = 0;

    typedef struct {
        int   x;
        logic nsf;
        int   exp_y;
        logic exp_sat;
    } vec_t;

    vec_t vecs[17];

    de_emphasis dut (
        .clk          (clk),
        .rst          (rst),
        .new_subframe (new_subframe),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .sat_flag     (sat_flag)
`ifdef DEEMPH_SAT_CNT_EN
        ,
        .sat_count    (sat_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic chk_count(input string name);
`ifdef DEEMPH_SAT_CNT_EN
        chk(name, int'(sat_count), cnt_model);
`endif
    endtask

    // Feed one sample with out_ready high and check the 3-cycle cadence
    task automatic do_sample(input int x, input logic nsf, input int exp_y,
                             input logic exp_sat, input string name);
        @(negedge clk);
        in_valid     = 1'b1;
        in_data      = 17'(x);
        new_subframe = nsf;
        out_ready    = 1'b1;
        @(posedge clk); #1;
        in_valid     = 1'b0;
        new_subframe = 1'b0;
        if (nsf) cnt_model = 0;
        chk({name, "_calc_valid"}, int'(out_valid), 0);
        chk({name, "_calc_ready"}, int'(in_ready), 0);
        @(posedge clk); #1;
        if (exp_sat && cnt_model < 65535) cnt_model++;
        chk({name, "_valid"}, int'(out_valid), 1);
        chk({name, "_data"}, int'($signed(out_data)), exp_y);
        chk({name, "_sat"}, int'(sat_flag), int'(exp_sat));
        chk_count({name, "_cnt"});
        @(posedge clk); #1;
        chk({name, "_idle_ready"}, int'(in_ready), 1);
        chk({name, "_idle_valid"}, int'(out_valid), 0);
    endtask

    logic [15:0] held_data;

    initial begin
        vecs[0]  = '{1000,   1'b0, 1000,   1'b0};
        vecs[1]  = '{0,      1'b0, 31,     1'b0};
        vecs[2]  = '{0,      1'b0, 0,      1'b0};
        vecs[3]  = '{65535,  1'b0, 32767,  1'b1};
        vecs[4]  = '{0,      1'b0, 1023,   1'b0};
        vecs[5]  = '{-65536, 1'b0, -32768, 1'b1};
        vecs[6]  = '{0,      1'b0, -1024,  1'b0};
        vecs[7]  = '{0,      1'b0, -32,    1'b0};
        vecs[8]  = '{0,      1'b0, -1,     1'b0};
        vecs[9]  = '{0,      1'b0, -1,     1'b0};
        vecs[10] = '{5,      1'b1, 5,      1'b0};
        vecs[11] = '{1000,   1'b0, 1000,   1'b0};
        vecs[12] = '{32736,  1'b0, 32767,  1'b0};
        vecs[13] = '{31745,  1'b0, 32767,  1'b1};
        vecs[14] = '{-33791, 1'b0, -32768, 1'b0};
        vecs[15] = '{-31745, 1'b0, -32768, 1'b1};
        vecs[16] = '{0,      1'b1, 0,      1'b0};

        rst          = 1'b1;
        new_subframe = 1'b0;
        in_valid     = 1'b0;
        in_data      = '0;
        out_ready    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_sat_flag", int'(sat_flag), 0);
        chk_count("rst_cnt");
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            do_sample(vecs[i].x, vecs[i].nsf, vecs[i].exp_y, vecs[i].exp_sat,
                      $sformatf("vec%0d", i));
        end

        // Backpressure with a subframe pulse while the result is held
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = 17'd1000;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("bp_first_valid", int'(out_valid), 1);
        chk("bp_first_data", int'($signed(out_data)), 1000);
        held_data = out_data;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            in_valid     = c[0];
            in_data      = 17'(c * 123 + 7);
            new_subframe = (c == 1);
            @(posedge clk); #1;
            chk($sformatf("bp_valid_%0d", c), int'(out_valid), 1);
            chk($sformatf("bp_data_%0d", c), int'(out_data), int'(held_data));
            chk($sformatf("bp_ready_%0d", c), int'(in_ready), 0);
        end
        @(negedge clk);
        in_valid     = 1'b0;
        new_subframe = 1'b0;
        out_ready    = 1'b1;
        @(posedge clk); #1;
        cnt_model = 0;
        chk("bp_release_valid", int'(out_valid), 0);
        chk("bp_release_ready", int'(in_ready), 1);
        do_sample(0, 1'b0, 0, 1'b0, "clr_hold");

        // Reset while a sample is being computed
        do_sample(1000, 1'b0, 1000, 1'b0, "pre_rst");
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 17'd500;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk); #1;
        rst       = 1'b0;
        cnt_model = 0;
        chk("mid_rst_valid", int'(out_valid), 0);
        chk("mid_rst_data", int'(out_data), 0);
        chk("mid_rst_sat", int'(sat_flag), 0);
        chk("mid_rst_ready", int'(in_ready), 1);
        @(posedge clk); #1;
        chk("mid_rst_no_output", int'(out_valid), 0);
        do_sample(64, 1'b0, 64, 1'b0, "post_rst");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
